data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter placed in front of the single-port `data_memory` (32 × 32-bit words, synchronous write, asynchronous read), so that the core's load/store path (port 0) and a program/data loader or debug master (port 1) can share it. It grants the memory to one owner at a time, supports short locked bursts, registers read data back to the owner, and flags out-of-range accesses. All memory-side outputs are driven combinationally from the registered owner state, so memory writes commit on the same edge that completes a beat.

## Interface
- `DW`, 32, data width
- `AW`, 32, address width (word index, as `data_memory` expects)
- `MEM_DEPTH`, 32, number of valid words; addresses ≥ `MEM_DEPTH` are out of range
- `MAX_BURST`, 4, maximum beats per locked grant (≥1)

- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `m0_req`/`m1_req` in 1: request; held high while the master has beats to issue
- `m0_we`/`m1_we` in 1: 1 = write beat, 0 = read beat
- `m0_lock`/`m1_lock` in 1: keep grant after this beat (burst)
- `m0_addr`/`m1_addr` in AW: word address
- `m0_wdata`/`m1_wdata` in DW: write data
- `m0_gnt`/`m1_gnt` out 1: port owns memory this cycle
- `m0_rdata`/`m1_rdata` out DW: registered read data
- `m0_rvalid`/`m1_rvalid` out 1: one-cycle pulse, rdata valid
- `m0_err`/`m1_err` out 1: one-cycle pulse, previous beat was out of range
- `mem_a` out AW, `mem_wd` out DW, `mem_we` out 1: to `data_memory` A/WD/WE
- `mem_rd` in DW: from `data_memory` RD

## Operation
- FSM states: IDLE, OWN0, OWN1. `mN_gnt` = (state == OWNN).
- Beat on port N: `mN_gnt & mN_req`. Memory outputs mux from owner; in IDLE `mem_a`=0, `mem_wd`=0, `mem_we`=0.
- `mem_we` = beat & owner `we` & (addr < MEM_DEPTH) & !reset.
- Out-of-range beat: no write; next cycle `mN_err`=1, and for a read `mN_rvalid`=1 with `mN_rdata`=0.
- In-range read beat: `mN_rdata` <= `mem_rd`, `mN_rvalid`=1 next cycle. Rdata holds until the next read beat on that port.
- Beat counter `bcnt` (clog2(MAX_BURST) bits): cleared on every ownership entry, incremented per beat.
- Release from OWNN at the edge when: `!mN_req`, or beat & `!mN_lock`, or beat & `bcnt == MAX_BURST-1`.
- On release or in IDLE, next owner chosen by arbitration among current `req` lines: other port if requesting, else same port if requesting, else IDLE. A port re-granted to itself starts a new burst (`bcnt` cleared).
- IDLE with both requesting: arbitration rule below (Configuration). A single requester is always granted.
- Grant is never revoked mid-burst except by `MAX_BURST` or `reset`.

## Timing
- Reset: state IDLE, `bcnt`=0, priority pointer favours port 0, all `gnt`/`rvalid`/`err` = 0, both `rdata` = 0. `mem_we` forced 0 during any cycle with `reset` high, including mid-burst; no write commits on that edge.
- Grant latency: request in IDLE → `gnt` the next cycle (1 cycle). Back-to-back handover between owners: zero bubble cycles.
- Write latency: data in memory on the edge completing the beat. Read latency: `rvalid` one cycle after the beat.
- Master must hold `addr`/`we`/`wdata` stable only during cycles where it has `gnt`; `req` dropped while granted ends ownership with no beat.
- Simultaneous release and other-port request: handover on the same edge.

## Configuration
- `DMA_ARB_ROUND_ROBIN_EN` defined: round-robin; on contention, the port not served most recently wins; pointer updates at each ownership entry.
- Not defined: fixed priority; port 0 always wins contention (release still forced by `!lock` or `MAX_BURST`, so port 1 gets a slot only when port 0 is not requesting).

## Test plan
- Reset, then `m0` write addr 5 data 0xDEADBEEF, then read addr 5 → `m0_gnt` cycle 1, `mem_we`=1 one cycle, `m0_rvalid` with 0xDEADBEEF one cycle after read beat.
- Both `req` high from IDLE, no lock → grants alternate 0,1,0,1 with RR macro; fixed-priority build: port 0 holds every cycle, `m1_gnt` stays 0.
- `m1` locked burst of 6 writes, addr 0..5, `m0` requesting → `m1` gets 4 beats, `m0` 1 beat, `m1` remaining 2; memory words 0..5 correct.
- `m0` write addr 40 → `mem_we`=0, `m0_err` pulse; read addr 40 → `m0_rvalid`=1, `m0_rdata`=0, `m0_err`=1.
- Assert `reset` mid-burst on a write beat → no write at that edge, all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-master arbiter in front of the single-port data_memory (sync write, async read).
// Define DMA_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise port 0 has fixed priority.
module data_mem_arbiter #(
   parameter int DW        = 32,
   parameter int AW        = 32,
   parameter int MEM_DEPTH = 32,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic          m0_lock,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic          m1_lock,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m0_gnt,
   output logic          m1_gnt,
   output logic [DW-1:0] m0_rdata,
   output logic [DW-1:0] m1_rdata,
   output logic          m0_rvalid,
   output logic          m1_rvalid,
   output logic          m0_err,
   output logic          m1_err,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_wd,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rd
);

   localparam int            BW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BW-1:0] BLAST = BW'(MAX_BURST - 1);
   localparam logic [AW-1:0] DEPTH = AW'(MEM_DEPTH);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t        state;
   state_t        arb;
   logic [BW-1:0] bcnt;
   logic          o_req;
   logic          o_we;
   logic          o_lock;
   logic [AW-1:0] o_addr;
   logic [DW-1:0] o_wdata;
   logic          beat;
   logic          beat0;
   logic          beat1;
   logic          in_range;
   logic          rel;
   logic          pick1;

   // Owner-side view of the bus; everything is zero while nobody owns the memory.
   always_comb begin
      o_req   = 1'b0;
      o_we    = 1'b0;
      o_lock  = 1'b0;
      o_addr  = '0;
      o_wdata = '0;
      case (state)
         OWN0: begin
            o_req   = m0_req;
            o_we    = m0_we;
            o_lock  = m0_lock;
            o_addr  = m0_addr;
            o_wdata = m0_wdata;
         end
         OWN1: begin
            o_req   = m1_req;
            o_we    = m1_we;
            o_lock  = m1_lock;
            o_addr  = m1_addr;
            o_wdata = m1_wdata;
         end
         default: ;
      endcase
   end

   assign beat     = o_req;
   assign beat0    = beat & (state == OWN0);
   assign beat1    = beat & (state == OWN1);
   assign in_range = (o_addr < DEPTH);
   assign rel      = (state != IDLE) & (~o_req | (beat & (~o_lock | (bcnt == BLAST))));

`ifdef DMA_ARB_ROUND_ROBIN_EN
   logic prio;
   assign pick1 = prio;
`else
   assign pick1 = 1'b0;
`endif

   always_comb begin
      arb = IDLE;
      if (m0_req && m1_req)
         arb = pick1 ? OWN1 : OWN0;
      else if (m0_req)
         arb = OWN0;
      else if (m1_req)
         arb = OWN1;
   end

   // Ownership FSM: every entry (including a self re-grant) starts a fresh burst.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         bcnt  <= '0;
`ifdef DMA_ARB_ROUND_ROBIN_EN
         prio  <= 1'b0;
`endif
      end else if ((state == IDLE) || rel) begin
         state <= arb;
         bcnt  <= '0;
`ifdef DMA_ARB_ROUND_ROBIN_EN
         if (arb != IDLE)
            prio <= (arb == OWN0);
`endif
      end else if (beat) begin
         bcnt <= bcnt + BW'(1);
      end
   end

   assign m0_gnt = (state == OWN0);
   assign m1_gnt = (state == OWN1);
   assign mem_a  = o_addr;
   assign mem_wd = o_wdata;
   assign mem_we = beat & o_we & in_range & ~reset;

   // Read return: out-of-range reads complete with zero data plus an error pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_err    <= 1'b0;
         m1_err    <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         m0_rvalid <= beat0 & ~o_we;
         m1_rvalid <= beat1 & ~o_we;
         m0_err    <= beat0 & ~in_range;
         m1_err    <= beat1 & ~in_range;
         if (beat0 & ~o_we)
            m0_rdata <= in_range ? mem_rd : '0;
         if (beat1 & ~o_we)
            m1_rdata <= in_range ? mem_rd : '0;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: queue-driven masters, a word-array memory behind the arbiter and a shadow-memory model.
module tb_data_mem_arbiter;

   typedef struct packed {
      logic        we;
      logic        lock;
      logic [31:0] addr;
      logic [31:0] wdata;
   } beat_t;

   logic        clk;
   logic        reset;
   logic        mem_clr;
   logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
   logic [31:0] m0_rdata, m1_rdata, mem_a, mem_wd, mem_rd;
   logic        mem_we;

   logic [31:0] tmem [32];
   logic [31:0] smem [32];
   beat_t       q0[$];
   beat_t       q1[$];
   int          log_port[$];
   int          log_cyc[$];
   int          st0, st1;
   logic        exp_rv0, exp_rv1, exp_er0, exp_er1;
   logic [31:0] exp_rd0, exp_rd1;
   int          total = 0;
   int          bad   = 0;

   data_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_err(m0_err), .m1_err(m1_err),
      .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // data_memory stand-in: synchronous write, asynchronous read
   always @(posedge clk) begin
      if (mem_clr)
         for (int i = 0; i < 32; i++) tmem[i] <= 32'h0;
      else if (mem_we)
         tmem[mem_a[4:0]] <= mem_wd;
   end
   assign mem_rd = (mem_a < 32) ? tmem[mem_a[4:0]] : 32'h0;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_idle();
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
   endtask

   task automatic clear_exp();
      exp_rv0 = 0; exp_rv1 = 0; exp_er0 = 0; exp_er1 = 0; exp_rd0 = 0; exp_rd1 = 0;
   endtask

   task automatic do_reset();
      drive_idle();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      clear_exp();
   endtask

   // Master driver plus model: a beat happens whenever a master requests while granted.
   task automatic run_beats(input int budget);
      logic bt0, bt1, ew;
      int   idle_cnt;
      bit   done;
      idle_cnt = 0;
      done     = 0;
      log_port.delete();
      log_cyc.delete();
      for (int cyc = 0; cyc < budget && !done; cyc++) begin
         total++;
         if (m0_rvalid !== exp_rv0 || m0_err !== exp_er0 || m0_rdata !== exp_rd0) begin
            bad++;
            $display("FAIL m0_return cyc=%0d got rv=%b err=%b rd=%h want rv=%b err=%b rd=%h",
                     cyc, m0_rvalid, m0_err, m0_rdata, exp_rv0, exp_er0, exp_rd0);
         end
         total++;
         if (m1_rvalid !== exp_rv1 || m1_err !== exp_er1 || m1_rdata !== exp_rd1) begin
            bad++;
            $display("FAIL m1_return cyc=%0d got rv=%b err=%b rd=%h want rv=%b err=%b rd=%h",
                     cyc, m1_rvalid, m1_err, m1_rdata, exp_rv1, exp_er1, exp_rd1);
         end
         drive_idle();
         if (cyc >= st0 && q0.size() > 0) begin
            m0_req = 1; m0_we = q0[0].we; m0_lock = q0[0].lock; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
         end
         if (cyc >= st1 && q1.size() > 0) begin
            m1_req = 1; m1_we = q1[0].we; m1_lock = q1[0].lock; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
         end
         #1;
         bt0 = m0_gnt & m0_req;
         bt1 = m1_gnt & m1_req;
         total++;
         if (m0_gnt === 1'b1 && m1_gnt === 1'b1) begin
            bad++;
            $display("FAIL dual_grant cyc=%0d got both gnt high want at most one", cyc);
         end
         ew = (bt0 & m0_we & (m0_addr < 32)) | (bt1 & m1_we & (m1_addr < 32));
         total++;
         if (mem_we !== ew) begin
            bad++;
            $display("FAIL mem_we cyc=%0d got %b want %b", cyc, mem_we, ew);
         end
         if (bt0 || bt1) begin
            total++;
            if (mem_a !== (bt0 ? m0_addr : m1_addr) || (ew && mem_wd !== (bt0 ? m0_wdata : m1_wdata))) begin
               bad++;
               $display("FAIL mem_bus cyc=%0d got a=%h wd=%h want a=%h wd=%h", cyc, mem_a, mem_wd,
                        bt0 ? m0_addr : m1_addr, bt0 ? m0_wdata : m1_wdata);
            end
         end
         exp_rv0 = 0; exp_er0 = 0; exp_rv1 = 0; exp_er1 = 0;
         if (bt0) begin
            exp_er0 = (m0_addr >= 32);
            if (!m0_we) begin
               exp_rv0 = 1;
               exp_rd0 = (m0_addr < 32) ? smem[m0_addr[4:0]] : 32'h0;
            end else if (m0_addr < 32) begin
               smem[m0_addr[4:0]] = m0_wdata;
            end
            log_port.push_back(0);
            log_cyc.push_back(cyc);
            void'(q0.pop_front());
         end
         if (bt1) begin
            exp_er1 = (m1_addr >= 32);
            if (!m1_we) begin
               exp_rv1 = 1;
               exp_rd1 = (m1_addr < 32) ? smem[m1_addr[4:0]] : 32'h0;
            end else if (m1_addr < 32) begin
               smem[m1_addr[4:0]] = m1_wdata;
            end
            log_port.push_back(1);
            log_cyc.push_back(cyc);
            void'(q1.pop_front());
         end
         step();
         if (q0.size() == 0 && q1.size() == 0) idle_cnt++;
         if (idle_cnt >= 3) done = 1;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL drain got pending q0=%0d q1=%0d want 0 within %0d cycles", q0.size(), q1.size(), budget);
         q0.delete();
         q1.delete();
      end
      drive_idle();
   endtask

   task automatic test_reset();
      drive_idle();
      reset   = 1'b1;
      mem_clr = 1'b1;
      step();
      total++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_we} !== 7'b0) begin
         bad++;
         $display("FAIL reset_ctrl got gnt=%b%b rv=%b%b err=%b%b we=%b want all 0",
                  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_we);
      end
      total++;
      if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_rdata got %h %h want 0 0", m0_rdata, m1_rdata);
      end
      step();
      reset   = 1'b0;
      mem_clr = 1'b0;
      for (int i = 0; i < 32; i++) smem[i] = 32'h0;
      clear_exp();
      step();
      total++;
      if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || mem_a !== 32'h0) begin
         bad++;
         $display("FAIL idle_no_req got gnt=%b%b a=%h want 00 0", m0_gnt, m1_gnt, mem_a);
      end
   endtask

   task automatic test_write_read();
      st0 = 0; st1 = 0;
      q0.push_back('{we: 1'b1, lock: 1'b0, addr: 32'd5, wdata: 32'hDEADBEEF});
      q0.push_back('{we: 1'b0, lock: 1'b0, addr: 32'd5, wdata: 32'h0});
      run_beats(40);
      total++;
      if (log_port.size() != 2 || log_cyc[0] != 1 || log_cyc[1] != 2) begin
         bad++;
         $display("FAIL wr_rd_timing got beats=%0d first_cyc=%0d want 2 beats at cycles 1,2",
                  log_port.size(), (log_cyc.size() > 0) ? log_cyc[0] : -1);
      end
      total++;
      if (tmem[5] !== 32'hDEADBEEF || m0_rdata !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL wr_rd_data got mem=%h rdata=%h want deadbeef", tmem[5], m0_rdata);
      end
   endtask

   task automatic test_contention();
      int exp_port [8];
      do_reset();
      st0 = 0; st1 = 0;
      for (int i = 0; i < 4; i++) begin
         q0.push_back('{we: 1'b0, lock: 1'b0, addr: 32'($urandom_range(0, 31)), wdata: 32'h0});
         q1.push_back('{we: 1'b0, lock: 1'b0, addr: 32'($urandom_range(0, 31)), wdata: 32'h0});
      end
      for (int i = 0; i < 8; i++) begin
`ifdef DMA_ARB_ROUND_ROBIN_EN
         exp_port[i] = i % 2;
`else
         exp_port[i] = (i < 4) ? 0 : 1;
`endif
      end
      run_beats(60);
      total++;
      if (log_port.size() != 8) begin
         bad++;
         $display("FAIL contention_beats got %0d want 8", log_port.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            total++;
            if (log_port[i] != exp_port[i]) begin
               bad++;
               $display("FAIL contention_order beat=%0d got port %0d want %0d", i, log_port[i], exp_port[i]);
            end
         end
         total++;
`ifdef DMA_ARB_ROUND_ROBIN_EN
         if (log_cyc[7] != 8) begin
`else
         if (log_cyc[0] != 1 || log_cyc[3] != 4) begin
`endif
            bad++;
            $display("FAIL contention_timing got first=%0d fourth=%0d last=%0d", log_cyc[0], log_cyc[3], log_cyc[7]);
         end
      end
   endtask

   task automatic test_burst();
      logic [31:0] wd [6];
      int          exp_port [7];
      exp_port = '{1, 1, 1, 1, 0, 1, 1};
      do_reset();
      st1 = 0; st0 = 1;
      for (int i = 0; i < 6; i++) begin
         wd[i] = $urandom;
         q1.push_back('{we: 1'b1, lock: (i != 5), addr: 32'(i), wdata: wd[i]});
      end
      q0.push_back('{we: 1'b1, lock: 1'b0, addr: 32'd12, wdata: 32'hA5A5_0012});
      run_beats(60);
      total++;
      if (log_port.size() != 7) begin
         bad++;
         $display("FAIL burst_beats got %0d want 7", log_port.size());
      end else begin
         for (int i = 0; i < 7; i++) begin
            total++;
            if (log_port[i] != exp_port[i]) begin
               bad++;
               $display("FAIL burst_order beat=%0d got port %0d want %0d", i, log_port[i], exp_port[i]);
            end
         end
      end
      for (int i = 0; i < 6; i++) begin
         total++;
         if (tmem[i] !== wd[i]) begin
            bad++;
            $display("FAIL burst_mem word=%0d got %h want %h", i, tmem[i], wd[i]);
         end
      end
   endtask

   task automatic test_out_of_range();
      st0 = 0; st1 = 0;
      q0.push_back('{we: 1'b1, lock: 1'b0, addr: 32'd40, wdata: 32'h1234_5678});
      q0.push_back('{we: 1'b0, lock: 1'b0, addr: 32'd40, wdata: 32'h0});
      run_beats(40);
      total++;
      if (m0_rdata !== 32'h0 || log_port.size() != 2) begin
         bad++;
         $display("FAIL oob_read got rdata=%h beats=%0d want 0 and 2", m0_rdata, log_port.size());
      end
      total++;
      if (tmem[8] !== smem[8] || tmem[0] !== smem[0]) begin
         bad++;
         $display("FAIL oob_alias got w8=%h w0=%h want %h %h", tmem[8], tmem[0], smem[8], smem[0]);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [31:0] old8;
      old8 = smem[8];
      drive_idle();
      m0_req = 1; m0_we = 1; m0_lock = 1; m0_addr = 32'd7; m0_wdata = 32'h0000_7777;
      step();
      total++;
      if (m0_gnt !== 1'b1 || mem_we !== 1'b1) begin
         bad++;
         $display("FAIL mid_first_beat got gnt=%b we=%b want 1 1", m0_gnt, mem_we);
      end
      step();
      m0_addr = 32'd8; m0_wdata = 32'h0000_8888;
      reset = 1'b1;
      #1;
      total++;
      if (mem_we !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_we got %b want 0", mem_we);
      end
      step();
      drive_idle();
      reset = 1'b0;
      total++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err} !== 6'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
         bad++;
         $display("FAIL mid_reset_outputs got gnt=%b%b rv=%b%b err=%b%b rd=%h/%h want all 0",
                  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, m0_rdata, m1_rdata);
      end
      total++;
      if (tmem[8] !== old8 || tmem[7] !== 32'h0000_7777) begin
         bad++;
         $display("FAIL mid_reset_mem got w7=%h w8=%h want 00007777 %h", tmem[7], tmem[8], old8);
      end
      smem[7] = 32'h0000_7777;
      clear_exp();
      step();
      total++;
      if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_idle got gnt=%b%b want 00", m0_gnt, m1_gnt);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         st0 = $urandom_range(0, 3);
         st1 = $urandom_range(0, 3);
         for (int i = 0; i < 16; i++) begin
            q0.push_back('{we: 1'($urandom_range(0, 1)), lock: ($urandom_range(0, 2) != 0),
                           addr: 32'($urandom_range(0, 39)), wdata: $urandom});
            q1.push_back('{we: 1'($urandom_range(0, 1)), lock: ($urandom_range(0, 2) != 0),
                           addr: 32'($urandom_range(0, 39)), wdata: $urandom});
         end
         run_beats(600);
         total++;
         if (log_port.size() != 32) begin
            bad++;
            $display("FAIL random_beats round=%0d got %0d want 32", r, log_port.size());
         end
      end
      for (int i = 0; i < 32; i++) begin
         total++;
         if (tmem[i] !== smem[i]) begin
            bad++;
            $display("FAIL random_mem word=%0d got %h want %h", i, tmem[i], smem[i]);
         end
      end
   endtask

   initial begin
      reset   = 1'b1;
      mem_clr = 1'b1;
      drive_idle();
      clear_exp();
      st0 = 0;
      st1 = 0;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_contention();
      test_burst();
      test_out_of_range();
      test_reset_mid_burst();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
